// File: rtl/frame_store_pkg.sv
// Shared constants, types and address-mapping helper for the background frame store.
package frame_store_pkg;

   localparam int ADDR_LSB   = 2;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;

   // One paired write: byte address plus pixel word.
   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [AXI_DATA_W-1:0] data;
   } wr_req_t;

   // Result of mapping a byte address: full word number and out-of-range flag.
   typedef struct packed {
      logic [AXI_ADDR_W-1:0] word;
      logic                  oor;
   } word_map_t;

   // Byte address -> word number; any bit above the index field flags out of range.
   function automatic word_map_t word_index(input logic [AXI_ADDR_W-1:0] addr,
                                            input int                    idx_bits);
      word_map_t m;
      m.word = addr >> ADDR_LSB;
      m.oor  = ((addr >> ADDR_LSB) >> idx_bits) != {AXI_ADDR_W{1'b0}};
      return m;
   endfunction

endpackage

// File: rtl/frame_store_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// read-first on same-index collision, one-cycle read latency.
// Storage is not reset; only the read data register is.
module frame_store_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   // Write port; the read below samples the pre-edge contents, giving read-first.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   // Load the read register only on an enabled read so data holds otherwise.
   always_comb begin
      rd_data_d = rd_data_q;
      if (re) begin
         rd_data_d = mem_q[rd_idx];
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Read data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/background_frame_store.sv
// Background frame store: AXI4-Lite style aw/w/ar/r slave in front of a word RAM.
// Pairs independent aw and w beats through 1-entry holding registers, serves
// reads with one-cycle latency and tracks a sticky out-of-range flag.
// Optional build macro FRAME_STORE_STATS_EN adds wr_count/rd_count outputs.
module background_frame_store
   import frame_store_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_W,
   parameter int DATA_WIDTH = AXI_DATA_W,
   parameter int DEPTH      = 2097152
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
`ifdef FRAME_STORE_STATS_EN
   output logic [31:0]           wr_count,
   output logic [31:0]           rd_count,
`endif
   output logic                  range_error
);

   localparam int IDX_BITS = $clog2(DEPTH);

   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rd_oor_q, rd_oor_d;
   logic                  range_error_q, range_error_d;

   logic                  aw_fire_s, w_fire_s, ar_fire_s, commit_s, ram_we_s, ram_re_s;
   wr_req_t               req_s;
   word_map_t             wr_map_s, rd_map_s;
   logic [IDX_BITS-1:0]   wr_idx_s, rd_idx_s;
   logic [DATA_WIDTH-1:0] ram_rdata_s;

   // Handshakes, write pairing and address mapping for this cycle.
   always_comb begin
      aw_fire_s = s_axi_awvalid & ~aw_held_q;
      w_fire_s  = s_axi_wvalid & ~w_held_q;
      ar_fire_s = s_axi_arvalid & (~rvalid_q | s_axi_rready);
      commit_s  = (aw_held_q | aw_fire_s) & (w_held_q | w_fire_s);
      req_s.addr = aw_held_q ? AXI_ADDR_W'(aw_addr_q) : AXI_ADDR_W'(s_axi_awaddr);
      req_s.data = w_held_q  ? AXI_DATA_W'(w_data_q)  : AXI_DATA_W'(s_axi_wdata);
      wr_map_s  = word_index(req_s.addr, IDX_BITS);
      rd_map_s  = word_index(AXI_ADDR_W'(s_axi_araddr), IDX_BITS);
      wr_idx_s  = IDX_BITS'(wr_map_s.word);
      rd_idx_s  = IDX_BITS'(rd_map_s.word);
      ram_we_s  = commit_s & ~wr_map_s.oor;
      ram_re_s  = ar_fire_s & ~rd_map_s.oor;
   end

   // Next-state for holding registers, read valid and the sticky error.
   always_comb begin
      aw_held_d = (aw_held_q | aw_fire_s) & ~(w_held_q | w_fire_s);
      w_held_d  = (w_held_q | w_fire_s) & ~(aw_held_q | aw_fire_s);
      if (aw_fire_s) begin
         aw_addr_d = s_axi_awaddr;
      end else begin
         aw_addr_d = aw_addr_q;
      end
      if (w_fire_s) begin
         w_data_d = s_axi_wdata;
      end else begin
         w_data_d = w_data_q;
      end
      if (ar_fire_s) begin
         rvalid_d = 1'b1;
         rd_oor_d = rd_map_s.oor;
      end else if (s_axi_rready) begin
         rvalid_d = 1'b0;
         rd_oor_d = rd_oor_q;
      end else begin
         rvalid_d = rvalid_q;
         rd_oor_d = rd_oor_q;
      end
      range_error_d = range_error_q | (commit_s & wr_map_s.oor) | (ar_fire_s & rd_map_s.oor);
   end

   // Control and holding-register state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_held_q     <= 1'b0;
         w_held_q      <= 1'b0;
         aw_addr_q     <= {ADDR_WIDTH{1'b0}};
         w_data_q      <= {DATA_WIDTH{1'b0}};
         rvalid_q      <= 1'b0;
         rd_oor_q      <= 1'b0;
         range_error_q <= 1'b0;
      end else begin
         aw_held_q     <= aw_held_d;
         w_held_q      <= w_held_d;
         aw_addr_q     <= aw_addr_d;
         w_data_q      <= w_data_d;
         rvalid_q      <= rvalid_d;
         rd_oor_q      <= rd_oor_d;
         range_error_q <= range_error_d;
      end
   end

   frame_store_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst),
      .we      (ram_we_s),
      .wr_idx  (wr_idx_s),
      .wr_data (DATA_WIDTH'(req_s.data)),
      .re      (ram_re_s),
      .rd_idx  (rd_idx_s),
      .rd_data (ram_rdata_s)
   );

   assign s_axi_awready = ~aw_held_q;
   assign s_axi_wready  = ~w_held_q;
   assign s_axi_arready = ~rvalid_q | s_axi_rready;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rd_oor_q ? {DATA_WIDTH{1'b0}} : ram_rdata_s;
   assign range_error   = range_error_q;

`ifdef FRAME_STORE_STATS_EN
   logic [31:0] wr_count_q, wr_count_d;
   logic [31:0] rd_count_q, rd_count_d;

   // Count in-range commits and r-channel handshakes, wrapping naturally.
   always_comb begin
      if (ram_we_s) begin
         wr_count_d = wr_count_q + 32'd1;
      end else begin
         wr_count_d = wr_count_q;
      end
      if (rvalid_q && s_axi_rready) begin
         rd_count_d = rd_count_q + 32'd1;
      end else begin
         rd_count_d = rd_count_q;
      end
   end

   // Statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count_q <= 32'd0;
         rd_count_q <= 32'd0;
      end else begin
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_background_frame_store.sv
// Self-checking bench for background_frame_store: directed scenarios plus a
// randomized phase, all checked against a queue/array reference model.
module tb_background_frame_store;

   localparam int DEPTH = 1024;
   localparam int NW    = 64;

   logic        clk;
   logic        rst;
   logic        s_axi_awvalid, s_axi_awready;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_wvalid, s_axi_wready;
   logic [31:0] s_axi_wdata;
   logic        s_axi_arvalid, s_axi_arready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_rdata;
   logic        range_error;
`ifdef FRAME_STORE_STATS_EN
   logic [31:0] wr_count, rd_count;
`endif

   background_frame_store #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_rdata   (s_axi_rdata),
`ifdef FRAME_STORE_STATS_EN
      .wr_count      (wr_count),
      .rd_count      (rd_count),
`endif
      .range_error   (range_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] mem_m [int];
   logic [31:0] aw_q [$];
   logic [31:0] w_q [$];
   bit          exp_rvalid;
   logic [31:0] exp_rdata;
   bit          exp_err;
   logic [31:0] wr_cnt, rd_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit is_oor(input logic [31:0] a);
      return (a >> 2) >= 32'(DEPTH);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = (32'($urandom_range(0, NW - 1)) << 2) | ($urandom & 32'd3);
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << (12 + $urandom_range(0, 19)));
      return a;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_m.exists(idx_of(a))) return mem_m[idx_of(a)];
      return 32'd0;
   endfunction

   // One clock cycle: called at posedge+1, drives inputs, checks, advances the model.
   task automatic cycle(input bit awv, input logic [31:0] awa, input bit wv, input logic [31:0] wd,
                        input bit arv, input logic [31:0] ara, input bit rr, output bit ar_fired);
      bit          e_awr, e_wr, e_arr, do_commit;
      logic [31:0] ca, cd;
      s_axi_awvalid = awv; s_axi_awaddr = awa;
      s_axi_wvalid  = wv;  s_axi_wdata  = wd;
      s_axi_arvalid = arv; s_axi_araddr = ara;
      s_axi_rready  = rr;
      #1;
      e_awr = (aw_q.size() == 0);
      e_wr  = (w_q.size() == 0);
      e_arr = !exp_rvalid || rr;
      chk("awready", 32'(s_axi_awready), 32'(e_awr));
      chk("wready", 32'(s_axi_wready), 32'(e_wr));
      chk("arready", 32'(s_axi_arready), 32'(e_arr));
      chk("rvalid", 32'(s_axi_rvalid), 32'(exp_rvalid));
      chk("range_error", 32'(range_error), 32'(exp_err));
      if (exp_rvalid) chk("rdata", s_axi_rdata, exp_rdata);
`ifdef FRAME_STORE_STATS_EN
      chk("wr_count", wr_count, wr_cnt);
      chk("rd_count", rd_count, rd_cnt);
`endif
      if (awv && e_awr) aw_q.push_back(awa);
      if (wv && e_wr) w_q.push_back(wd);
      do_commit = 1'b0;
      ca = 32'd0;
      cd = 32'd0;
      if (aw_q.size() > 0 && w_q.size() > 0) begin
         ca = aw_q.pop_front();
         cd = w_q.pop_front();
         do_commit = 1'b1;
      end
      if (exp_rvalid && rr) rd_cnt++;
      ar_fired = arv && e_arr;
      if (ar_fired) begin
         exp_rvalid = 1'b1;
         if (is_oor(ara)) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
         end else begin
            exp_rdata = mem_read(ara);
         end
      end else if (rr) begin
         exp_rvalid = 1'b0;
      end
      if (do_commit) begin
         if (is_oor(ca)) exp_err = 1'b1;
         else begin
            mem_m[idx_of(ca)] = cd;
            wr_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          f;
      int          n;
      int          budget;
      bit          rr;
      logic [31:0] w0;

      rst = 1'b0;
      s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0;
      s_axi_wvalid  = 1'b0; s_axi_wdata  = 32'd0;
      s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0;
      s_axi_rready  = 1'b0;
      exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
      wr_cnt = 32'd0; rd_cnt = 32'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 32'(s_axi_awready), 32'd1);
      chk("rst_wready", 32'(s_axi_wready), 32'd1);
      chk("rst_arready", 32'(s_axi_arready), 32'd1);
      chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      chk("rst_range_error", 32'(range_error), 32'd0);
      rst = 1'b1;

      // Prefill the words the rest of the bench uses
      for (int i = 0; i < NW; i++) cycle(1'b1, 32'(i * 4), 1'b1, $urandom, 1'b0, 32'd0, 1'b1, f);

      // aw+w same cycle, then read back
      cycle(1'b1, 32'h10, 1'b1, 32'hA5A5A5A5, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, f);
      chk("t1_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("t1_rdata", s_axi_rdata, 32'hA5A5A5A5);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      // Lone aw, data three cycles later
      cycle(1'b1, 32'h20, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      chk("t2_awready_low", 32'(s_axi_awready), 32'd0);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b1, 32'h11223344, 1'b0, 32'd0, 1'b1, f);
      chk("t2_awready_back", 32'(s_axi_awready), 32'd1);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, f);
      chk("t2_rdata", s_axi_rdata, 32'h11223344);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      // Burst of 8 reads with rready toggling
      n = 0; budget = 0; rr = 1'b1;
      while (n < 8 && budget < 64) begin
         cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'(n * 4), rr, f);
         if (f) n++;
         rr = !rr;
         budget++;
      end
      chk("burst_count", 32'(n), 32'd8);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      // Read/write collision returns the old word
      cycle(1'b1, 32'h40, 1'b1, 32'h00000001, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 1'b1, 32'h40, 1'b1, f);
      chk("coll_old", s_axi_rdata, 32'h00000001);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1, f);
      chk("coll_new", s_axi_rdata, 32'hDEADBEEF);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      // Out-of-range write and read
      w0 = mem_read(32'd0);
      cycle(1'b1, 32'(DEPTH * 4), 1'b1, 32'hCAFEF00D, 1'b1, 32'(DEPTH * 4), 1'b1, f);
      chk("oor_rdata", s_axi_rdata, 32'd0);
      chk("oor_err", 32'(range_error), 32'd1);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, f);
      chk("oor_mem_unchanged", s_axi_rdata, w0);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      chk("oor_err_sticky", 32'(range_error), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 3) != 0), f);
      end
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      // Pair off anything left in a holding register
      cycle(1'b1, 32'h0, 1'b1, 32'h5A5A0000, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      // Mid-operation reset with a read in flight and an address held
      cycle(1'b1, 32'h14, 1'b0, 32'd0, 1'b1, 32'hC, 1'b0, f);
      s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      #1;
      chk("pre_rst_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("pre_rst_awready", 32'(s_axi_awready), 32'd0);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("mid_rst_awready", 32'(s_axi_awready), 32'd1);
      chk("mid_rst_wready", 32'(s_axi_wready), 32'd1);
      chk("mid_rst_rdata", s_axi_rdata, 32'd0);
      chk("mid_rst_range_error", 32'(range_error), 32'd0);
`ifdef FRAME_STORE_STATS_EN
      chk("mid_rst_wr_count", wr_count, 32'd0);
      chk("mid_rst_rd_count", rd_count, 32'd0);
`endif
      aw_q.delete(); w_q.delete();
      exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
      wr_cnt = 32'd0; rd_cnt = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Lost aw must not pair with fresh data
      cycle(1'b0, 32'd0, 1'b1, 32'h0BADF00D, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b1, 32'h18, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b1, f);
      chk("post_rst_pair", s_axi_rdata, 32'h0BADF00D);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h14, 1'b1, f);
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
